// File: rtl/muldiv_pkg.sv
// Shared types and width-derived constants for the multicycle multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    function automatic int mul_steps(input int width);
        return width / 2;
    endfunction

    function automatic int div_steps(input int width);
        return width;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(div_steps(width));
    endfunction

    localparam int MUL_STEPS = mul_steps(DEF_WIDTH);
    localparam int DIV_STEPS = div_steps(DEF_WIDTH);
    localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth recode-and-add: returns acc plus the recoded multiple of the
// multiplicand, before the arithmetic right shift applied by the caller.
module booth_r4_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] acc_i,
    input  logic [2:0]       window_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    output logic [WIDTH+1:0] sum_o
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] addend;

    assign m_ext = {{2{multiplicand_i[WIDTH-1]}}, multiplicand_i};

    always_comb begin
        addend = '0;
        case (window_i)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
    end

    assign sum_o = acc_i + addend;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed multiply (radix-4 Booth) and signed restoring divide with a
// start/busy/done handshake; results feed the HI/LO registers.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int            MUL_N    = mul_steps(WIDTH);
    localparam int            DIV_N    = div_steps(WIDTH);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_N - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prep_q, prep_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    // Multiply datapath: Booth add, then shift {acc, mreg, carry} right by two.
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH+1:0] mul_acc_nxt;
    logic [WIDTH-1:0] mul_mreg_nxt;

    booth_r4_step #(.WIDTH(WIDTH)) u_booth (
        .acc_i          (acc_q),
        .window_i       ({mreg_q[1:0], carry_q}),
        .multiplicand_i (a_q),
        .sum_o          (booth_sum)
    );

    assign mul_acc_nxt  = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
    assign mul_mreg_nxt = {booth_sum[1:0], mreg_q[WIDTH-1:2]};

    // Divide datapath: acc holds the partial remainder, mreg shifts the dividend
    // out at the top while quotient bits enter at the bottom.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   div_shift, div_diff, div_rem_nxt;
    logic             div_ge;
    logic [WIDTH-1:0] div_quo_nxt, quo_signed, rem_signed;

    assign a_neg       = a_q[WIDTH-1];
    assign b_neg       = b_q[WIDTH-1];
    assign a_mag       = a_neg ? -a_q : a_q;
    assign b_mag       = b_neg ? -b_q : b_q;
    assign div_shift   = {acc_q[WIDTH-1:0], mreg_q[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, b_mag};
    assign div_ge      = ~div_diff[WIDTH];
    assign div_rem_nxt = div_ge ? div_diff : div_shift;
    assign div_quo_nxt = {mreg_q[WIDTH-2:0], div_ge};
    assign quo_signed  = (a_neg ^ b_neg) ? -div_quo_nxt : div_quo_nxt;
    assign rem_signed  = a_neg ? -div_rem_nxt[WIDTH-1:0] : div_rem_nxt[WIDTH-1:0];

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mreg_d  = mreg_q;
        carry_d = carry_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    prep_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = (op_e'(op) == OP_DIV) ? DIV : MUL;
                end else begin
                    state_d = IDLE;
                end
            end

            MUL: begin
                if (prep_q) begin
                    prep_d  = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mreg_d  = b_q;
                    carry_d = 1'b0;
                end else begin
                    acc_d   = mul_acc_nxt;
                    mreg_d  = mul_mreg_nxt;
                    carry_d = mreg_q[1];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == MUL_LAST) begin
                        state_d = DONE;
                        hi_d    = mul_acc_nxt[WIDTH-1:0];
                        lo_d    = mul_mreg_nxt;
                    end
                end
            end

            DIV: begin
                if (prep_q) begin
                    // The zero-divisor test runs on the latched operand; no iteration follows.
                    prep_d = 1'b0;
                    if (b_q == '0) begin
                        state_d = DONE;
                        hi_d    = a_q;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        cnt_d  = '0;
                        acc_d  = '0;
                        mreg_d = a_mag;
                    end
                end else begin
                    acc_d  = {1'b0, div_rem_nxt};
                    mreg_d = div_quo_nxt;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == DIV_LAST) begin
                        state_d = DONE;
                        hi_d    = rem_signed;
                        lo_d    = quo_signed;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mreg_q  <= '0;
            carry_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mreg_q  <= mreg_d;
            carry_q <= carry_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
